// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcodes, state encodings and ALU select codes for the processor controller
package proc_pkg;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_JZ    = 4'd7;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9,
        S_JMP    = 4'd10,
        S_JZ     = 4'd11,
        S_PAUSE  = 4'd12
    } state_t;

endpackage

// File: rtl/proc_control_unit.sv
// rtl/proc_control_unit.sv - fetch/decode/execute control FSM with branching and single-step debug
module proc_control_unit
    import proc_pkg::*;
#(
    parameter int PC_W    = 5,
    parameter int DADDR_W = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [15:0]        IR,
    input  logic               RF_Rp_zero,
    input  logic               StepMode,
    input  logic               Step,
    output logic               PC_clr,
    output logic               PC_up,
    output logic               PC_ld,
    output logic [PC_W-1:0]    PC_ld_addr,
    output logic               IR_ld,
    output logic [DADDR_W-1:0] D_addr,
    output logic               D_wr,
    output logic               RF_s,
    output logic [3:0]         RF_W_addr,
    output logic               RF_W_en,
    output logic [3:0]         RF_Ra_addr,
    output logic [3:0]         RF_Rb_addr,
    output logic [2:0]         ALU_s,
    output logic [3:0]         state_o,
    output logic               halted,
    output logic               illegal
);

    if (PC_W < 1 || PC_W > 8) begin : g_bad_pc_w
        $error("proc_control_unit: PC_W must be 1..8");
    end
    if (DADDR_W != 8) begin : g_bad_daddr_w
        $error("proc_control_unit: DADDR_W must be 8");
    end

    state_t state_q, state_d;
    logic   step_q;
    state_t exec_exit;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_INIT;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= Step;
        end
    end

    always_comb begin
        state_d   = state_q;
        exec_exit = StepMode ? S_PAUSE : S_FETCH;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (IR[15:12])
                    OP_NOOP:  state_d = S_NOOP;
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    OP_JMP:   state_d = S_JMP;
                    OP_JZ:    state_d = S_JZ;
                    default:  state_d = S_NOOP;
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB, S_JMP, S_JZ:
                      state_d = exec_exit;
            S_HALT:   state_d = S_HALT;
            // Only a fresh rising edge of Step releases; a held Step stays paused
            S_PAUSE:  if (Step && !step_q) state_d = S_FETCH;
            default:  state_d = S_INIT;
        endcase
    end

    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        PC_ld      = 1'b0;
        PC_ld_addr = '0;
        IR_ld      = 1'b0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = 4'd0;
        RF_Rb_addr = 4'd0;
        ALU_s      = ALU_PASS;
        halted     = 1'b0;
        illegal    = 1'b0;
        state_o    = state_q;
        case (state_q)
            S_INIT:   PC_clr = 1'b1;
            S_FETCH: begin
                IR_ld = 1'b1;
                PC_up = 1'b1;
            end
            S_DECODE: illegal = IR[15];
            S_LOAD_A, S_LOAD_B: begin
                D_addr    = IR[11:4];
                RF_s      = 1'b1;
                RF_W_addr = IR[3:0];
                RF_W_en   = (state_q == S_LOAD_B);
            end
            S_STORE: begin
                D_addr     = IR[7:0];
                RF_Ra_addr = IR[11:8];
                D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = IR[11:8];
                RF_Rb_addr = IR[7:4];
                RF_W_addr  = IR[3:0];
                RF_W_en    = 1'b1;
                ALU_s      = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            S_HALT:   halted = 1'b1;
            S_JMP: begin
                PC_ld      = 1'b1;
                PC_ld_addr = IR[PC_W-1:0];
            end
            S_JZ: begin
                RF_Ra_addr = IR[11:8];
                PC_ld_addr = IR[PC_W-1:0];
                PC_ld      = RF_Rp_zero;
            end
            default: ;
        endcase
    end

endmodule
